// File: rtl/wb_scratch_pkg.sv
// Shared types and constants for the Wishbone scratch responder.
package wb_scratch_pkg;

    // Value returned by status word 0 so software can identify the block.
    localparam logic [31:0] c_SCRATCH_ID = 32'h5C5A_0001;

    // Word offsets inside the status window (window bit set).
    localparam int c_STAT_ID   = 0;
    localparam int c_STAT_WCNT = 1;
    localparam int c_STAT_RCNT = 2;
    localparam int c_STAT_LAST = 3;

    // One queued response: valid marks a live slot, err replaces ack,
    // dat carries read data (zero for writes and errors).
    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] dat;
    } t_resp;

endpackage

// File: rtl/wb_scratch_responder_if.sv
// Pipelined Wishbone B4 bus bundle between a host master and the scratch slave.
//
// Handshake: a request is accepted on a rising clock edge where
// wb_cyc_i & wb_stb_i & !wb_stall_o. Every accepted request gets exactly one
// response (wb_ack_o or wb_err_o, a one-cycle pulse) in acceptance order.
// Dropping wb_cyc_i abandons all responses still owed. wb_dat_o is only
// meaningful while wb_ack_o is high and reads as zero otherwise.
interface wb_scratch_responder_if;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [31:0] wb_adr_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic        wb_stall_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
        input  wb_dat_o, wb_ack_o, wb_err_o, wb_stall_o
    );

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
        output wb_dat_o, wb_ack_o, wb_err_o, wb_stall_o
    );
endinterface

// File: rtl/wb_scratch_resp_pipe.sv
// Fixed-length response delay line. A response entered on an edge appears at
// resp_o after g_latency-1 further edges, so the master samples it exactly
// g_latency cycles after acceptance. flush_i empties every slot.
module wb_scratch_resp_pipe
    import wb_scratch_pkg::*;
#(
    parameter int g_latency = 2
) (
    input  logic  clk_i,
    input  logic  rst_n_i,
    input  logic  flush_i,
    input  t_resp resp_i,
    output t_resp resp_o,
    output logic  pop_o
);

    t_resp stage_q [g_latency];

    // Shift responses toward the output; flush or reset clears all slots.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < g_latency; i++) begin
                stage_q[i] <= '0;
            end
        end else if (flush_i) begin
            for (int i = 0; i < g_latency; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= resp_i;
            for (int i = 1; i < g_latency; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign resp_o = stage_q[g_latency-1];

    // pop_o marks the edge on which a response moves into the output slot,
    // i.e. the moment that request counts as answered.
    if (g_latency == 1) begin : g_pop_direct
        assign pop_o = resp_i.valid;
    end else begin : g_pop_stage
        assign pop_o = stage_q[g_latency-2].valid;
    end

endmodule

// File: rtl/wb_scratch_responder.sv
// Pipelined Wishbone B4 scratch target: byte-writable RAM plus a status
// window (ID, write/read counters, last written address) with fixed ack
// latency and a bounded number of outstanding requests.
module wb_scratch_responder
    import wb_scratch_pkg::*;
#(
    parameter int g_addr_bits       = 8,
    parameter int g_ack_latency     = 2,
    parameter int g_max_outstanding = 4
) (
    input  logic                   clk_sys_i,
    input  logic                   rst_n_i,
    wb_scratch_responder_if.slave  wb
);

    localparam int c_WORDS = 2 ** g_addr_bits;
    localparam int c_NW    = 4;  // holds 0..8 outstanding

    logic [g_addr_bits-1:0] word_idx;
    logic                   win_sel;
    logic                   accept;
    logic                   ram_wr;
    logic                   ram_rd;
    logic                   stat_clr;
    t_resp                  resp_in;
    t_resp                  resp_out;
    logic                   pop;
    logic                   ack;
    logic                   err;
    logic                   unused_adr;

    logic [31:0]            mem_q [c_WORDS];
    logic [31:0]            wcnt_q, wcnt_d;
    logic [31:0]            rcnt_q, rcnt_d;
    logic [31:0]            last_q, last_d;
    logic [c_NW-1:0]        outst_q, outst_d;
    logic                   stall_q, stall_d;

    assign word_idx   = wb.wb_adr_i[g_addr_bits+1:2];
    assign win_sel    = wb.wb_adr_i[g_addr_bits+2];
    // Upper bits are decoded by the crossbar, low bits are byte lanes.
    assign unused_adr = ^{wb.wb_adr_i[31:g_addr_bits+3], wb.wb_adr_i[1:0]};

    // Reset gates acceptance so no write can land while rst_n_i is low.
    assign accept = rst_n_i & wb.wb_cyc_i & wb.wb_stb_i & ~stall_q;

    // Decode the accepted request into a RAM action and its response.
    always_comb begin
        resp_in  = '0;
        ram_wr   = 1'b0;
        ram_rd   = 1'b0;
        stat_clr = 1'b0;
        if (accept) begin
            resp_in.valid = 1'b1;
            if (!win_sel) begin
                ram_wr = wb.wb_we_i;
                ram_rd = ~wb.wb_we_i;
                if (!wb.wb_we_i) begin
                    // Combinational read sees a write committed on the prior edge.
                    resp_in.dat = mem_q[word_idx];
                end
            end else if (word_idx == g_addr_bits'(c_STAT_LAST)) begin
                if (wb.wb_we_i) begin
                    stat_clr = 1'b1;
                end else begin
                    resp_in.dat = last_q;
                end
            end else if (wb.wb_we_i) begin
                resp_in.err = 1'b1;
            end else if (word_idx == g_addr_bits'(c_STAT_ID)) begin
                resp_in.dat = c_SCRATCH_ID;
            end else if (word_idx == g_addr_bits'(c_STAT_WCNT)) begin
                resp_in.dat = wcnt_q;
            end else if (word_idx == g_addr_bits'(c_STAT_RCNT)) begin
                resp_in.dat = rcnt_q;
            end else begin
                resp_in.err = 1'b1;
            end
        end
    end

    // Next-state for counters, last address and the outstanding tally.
    always_comb begin
        wcnt_d = wcnt_q;
        rcnt_d = rcnt_q;
        last_d = last_q;
        if (stat_clr) begin
            wcnt_d = '0;
            rcnt_d = '0;
            last_d = '0;
        end else begin
            if (ram_wr) begin
                wcnt_d = wcnt_q + 32'd1;
                last_d = {wb.wb_adr_i[31:2], 2'b00};
            end
            if (ram_rd) begin
                rcnt_d = rcnt_q + 32'd1;
            end
        end
        // A dropped cycle forgets every owed response.
        if (!wb.wb_cyc_i) begin
            outst_d = '0;
        end else begin
            outst_d = outst_q + c_NW'(accept) - c_NW'(pop);
        end
        stall_d = (outst_d == c_NW'(g_max_outstanding));
    end

    // Status and flow-control registers.
    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wcnt_q  <= '0;
            rcnt_q  <= '0;
            last_q  <= '0;
            outst_q <= '0;
            stall_q <= 1'b0;
        end else begin
            wcnt_q  <= wcnt_d;
            rcnt_q  <= rcnt_d;
            last_q  <= last_d;
            outst_q <= outst_d;
            stall_q <= stall_d;
        end
    end

    // Scratch RAM write port with byte enables; contents survive reset.
    always_ff @(posedge clk_sys_i) begin
        if (ram_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (wb.wb_sel_i[b]) begin
                    mem_q[word_idx][8*b +: 8] <= wb.wb_dat_i[8*b +: 8];
                end
            end
        end
    end

    wb_scratch_resp_pipe #(
        .g_latency (g_ack_latency)
    ) u_pipe (
        .clk_i   (clk_sys_i),
        .rst_n_i (rst_n_i),
        .flush_i (~wb.wb_cyc_i),
        .resp_i  (resp_in),
        .resp_o  (resp_out),
        .pop_o   (pop)
    );

    // Responses are never shown to a master that has left the cycle.
    assign ack           = resp_out.valid & ~resp_out.err & wb.wb_cyc_i;
    assign err           = resp_out.valid &  resp_out.err & wb.wb_cyc_i;
    assign wb.wb_ack_o   = ack;
    assign wb.wb_err_o   = err;
    assign wb.wb_dat_o   = ack ? resp_out.dat : 32'h0;
    assign wb.wb_stall_o = stall_q;

endmodule

// File: tb/tb_wb_scratch_responder.sv
// Directed bench for wb_scratch_responder: instance A (latency 2, depth 4)
// runs the single-transfer vector table and the abort/reset sequences,
// instance B (latency 4, depth 2) runs the stalled back-to-back burst.
module tb_wb_scratch_responder;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    wb_scratch_responder_if a_bus ();
    wb_scratch_responder_if b_bus ();

    wb_scratch_responder #(
        .g_addr_bits       (8),
        .g_ack_latency     (2),
        .g_max_outstanding (4)
    ) dut_a (
        .clk_sys_i (clk),
        .rst_n_i   (rst_n),
        .wb        (a_bus)
    );

    wb_scratch_responder #(
        .g_addr_bits       (8),
        .g_ack_latency     (4),
        .g_max_outstanding (2)
    ) dut_b (
        .clk_sys_i (clk),
        .rst_n_i   (rst_n),
        .wb        (b_bus)
    );

    typedef struct packed {
        logic        we;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic        exp_err;
        logic        chk_dat;
        logic [31:0] exp_dat;
    } vec_t;

    localparam int NVEC = 20;
    vec_t vecs [NVEC];

    int          n_ack, n_err, lat;
    logic [31:0] rdat;

    // scoreboard for instance B: bit 32 = compare data
    logic [32:0] exp_q [$];
    logic [32:0] b_exp;
    int          b_acks = 0;

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic a_idle();
        a_bus.wb_cyc_i = 1'b0;
        a_bus.wb_stb_i = 1'b0;
        a_bus.wb_we_i  = 1'b0;
        a_bus.wb_adr_i = '0;
        a_bus.wb_sel_i = '0;
        a_bus.wb_dat_i = '0;
    endtask

    task automatic b_idle();
        b_bus.wb_cyc_i = 1'b0;
        b_bus.wb_stb_i = 1'b0;
        b_bus.wb_we_i  = 1'b0;
        b_bus.wb_adr_i = '0;
        b_bus.wb_sel_i = '0;
        b_bus.wb_dat_i = '0;
    endtask

    // ---------------- driver tasks ----------------
    // One isolated transfer on A; reports response counts, latency in cycles
    // after the acceptance edge, and the data seen with ack.
    task automatic xfer(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                        input logic [31:0] dat, output int o_ack, output int o_err,
                        output int o_lat, output logic [31:0] o_dat);
        @(negedge clk);
        a_bus.wb_cyc_i = 1'b1;
        a_bus.wb_stb_i = 1'b1;
        a_bus.wb_we_i  = we;
        a_bus.wb_adr_i = adr;
        a_bus.wb_sel_i = sel;
        a_bus.wb_dat_i = dat;
        @(posedge clk);
        o_ack = 0;
        o_err = 0;
        o_lat = 0;
        o_dat = '0;
        for (int j = 1; j <= 8; j++) begin
            @(negedge clk);
            a_bus.wb_stb_i = 1'b0;
            if ((a_bus.wb_ack_o || a_bus.wb_err_o) && o_lat == 0) o_lat = j;
            if (a_bus.wb_ack_o) begin
                o_ack++;
                o_dat = a_bus.wb_dat_o;
            end
            if (a_bus.wb_err_o) o_err++;
        end
        a_idle();
    endtask

    // Back-to-back requests on B with stb held; honours stall and pushes the
    // expected responses at each acceptance.
    task automatic b_burst(input int n, input logic we, input logic [31:0] seed,
                           input logic chk_stall);
        int  i;
        int  guard;
        logic go;
        i     = 0;
        guard = 0;
        @(negedge clk);
        b_bus.wb_cyc_i = 1'b1;
        while (i < n && guard < 200) begin
            b_bus.wb_stb_i = 1'b1;
            b_bus.wb_we_i  = we;
            b_bus.wb_adr_i = 32'(4 * i);
            b_bus.wb_sel_i = 4'hF;
            b_bus.wb_dat_i = we ? seed + 32'(i) : 32'h0;
            go = !b_bus.wb_stall_o;
            @(posedge clk);
            if (go) begin
                exp_q.push_back(we ? 33'h0 : {1'b1, seed + 32'(i)});
                i++;
            end
            @(negedge clk);
            if (go && i == 2 && chk_stall) check("t3_stall_after_2nd", 32'(b_bus.wb_stall_o), 32'd1);
            guard++;
        end
        b_bus.wb_stb_i = 1'b0;
        if (i < n) check("t3_burst_budget", 32'(i), 32'(n));
    endtask

    // ---------------- scoreboard monitor for B ----------------
    always @(negedge clk) begin
        if (b_bus.wb_ack_o || b_bus.wb_err_o) begin
            b_acks++;
            if (exp_q.size() == 0) begin
                check("t3_unexpected_resp", 32'd1, 32'd0);
            end else begin
                b_exp = exp_q.pop_front();
                check("t3_err", 32'(b_bus.wb_err_o), 32'd0);
                if (b_exp[32]) check("t3_rdat", b_bus.wb_dat_o, b_exp[31:0]);
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        a_idle();
        b_idle();

        //               we    adr           sel   dat           err   chk   exp_dat
        vecs[0]  = '{1'b1, 32'h0000_021C, 4'hF, 32'h0000_FAFA, 1'b0, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 32'h0000_021C, 4'hF, 32'h0,         1'b0, 1'b1, 32'h0000_FAFA};
        vecs[2]  = '{1'b1, 32'h0000_0100, 4'hF, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0};
        vecs[3]  = '{1'b1, 32'h0000_0100, 4'h4, 32'h00CA_0000, 1'b0, 1'b0, 32'h0};
        vecs[4]  = '{1'b0, 32'h0000_0100, 4'hF, 32'h0,         1'b0, 1'b1, 32'hDECA_BEEF};
        vecs[5]  = '{1'b1, 32'h0000_0104, 4'hF, 32'h1122_3344, 1'b0, 1'b0, 32'h0};
        vecs[6]  = '{1'b1, 32'h0000_0104, 4'h0, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0};
        vecs[7]  = '{1'b0, 32'h0000_0104, 4'hF, 32'h0,         1'b0, 1'b1, 32'h1122_3344};
        vecs[8]  = '{1'b0, 32'h8000_021C, 4'hF, 32'h0,         1'b0, 1'b1, 32'h0000_FAFA};
        vecs[9]  = '{1'b0, 32'h0000_0400, 4'hF, 32'h0,         1'b0, 1'b1, 32'h5C5A_0001};
        vecs[10] = '{1'b1, 32'h0000_0404, 4'hF, 32'h1234_5678, 1'b1, 1'b0, 32'h0};
        vecs[11] = '{1'b0, 32'h0000_0414, 4'hF, 32'h0,         1'b1, 1'b0, 32'h0};
        vecs[12] = '{1'b1, 32'h0000_0400, 4'hF, 32'h0000_0001, 1'b1, 1'b0, 32'h0};
        vecs[13] = '{1'b0, 32'h0000_0404, 4'hF, 32'h0,         1'b0, 1'b1, 32'd5};
        vecs[14] = '{1'b0, 32'h0000_0408, 4'hF, 32'h0,         1'b0, 1'b1, 32'd4};
        vecs[15] = '{1'b0, 32'h0000_040C, 4'hF, 32'h0,         1'b0, 1'b1, 32'h0000_0104};
        vecs[16] = '{1'b1, 32'h0000_040C, 4'hF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0};
        vecs[17] = '{1'b0, 32'h0000_0404, 4'hF, 32'h0,         1'b0, 1'b1, 32'd0};
        vecs[18] = '{1'b0, 32'h0000_0408, 4'hF, 32'h0,         1'b0, 1'b1, 32'd0};
        vecs[19] = '{1'b0, 32'h0000_040C, 4'hF, 32'h0,         1'b0, 1'b1, 32'd0};

        // reset state
        repeat (3) @(negedge clk);
        check("rst_a_ack",   32'(a_bus.wb_ack_o),   32'd0);
        check("rst_a_err",   32'(a_bus.wb_err_o),   32'd0);
        check("rst_a_stall", 32'(a_bus.wb_stall_o), 32'd0);
        check("rst_a_dat",   a_bus.wb_dat_o,        32'd0);
        check("rst_b_stall", 32'(b_bus.wb_stall_o), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // T1/T2/T4: vector table, one transfer at a time
        for (int i = 0; i < NVEC; i++) begin
            xfer(vecs[i].we, vecs[i].adr, vecs[i].sel, vecs[i].dat, n_ack, n_err, lat, rdat);
            check($sformatf("v%0d_ack", i), 32'(n_ack), vecs[i].exp_err ? 32'd0 : 32'd1);
            check($sformatf("v%0d_err", i), 32'(n_err), vecs[i].exp_err ? 32'd1 : 32'd0);
            check($sformatf("v%0d_lat", i), 32'(lat), 32'd2);
            if (vecs[i].chk_dat) check($sformatf("v%0d_dat", i), rdat, vecs[i].exp_dat);
        end

        // read-after-write back-to-back with stb held
        @(negedge clk);
        a_bus.wb_cyc_i = 1'b1;
        a_bus.wb_stb_i = 1'b1;
        a_bus.wb_we_i  = 1'b1;
        a_bus.wb_adr_i = 32'h0000_0200;
        a_bus.wb_sel_i = 4'hF;
        a_bus.wb_dat_i = 32'hA5A5_A5A5;
        @(posedge clk);
        @(negedge clk);
        a_bus.wb_we_i  = 1'b0;
        a_bus.wb_dat_i = 32'h0;
        check("b2b_stall", 32'(a_bus.wb_stall_o), 32'd0);
        @(posedge clk);
        n_ack = 0;
        rdat  = '0;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            a_bus.wb_stb_i = 1'b0;
            if (a_bus.wb_ack_o) begin
                n_ack++;
                rdat = a_bus.wb_dat_o;
            end
        end
        a_idle();
        check("b2b_acks", 32'(n_ack), 32'd2);
        check("b2b_rdat", rdat, 32'hA5A5_A5A5);

        // T5: two writes accepted, cycle dropped before their acks
        @(negedge clk);
        a_bus.wb_cyc_i = 1'b1;
        a_bus.wb_stb_i = 1'b1;
        a_bus.wb_we_i  = 1'b1;
        a_bus.wb_adr_i = 32'h0000_0300;
        a_bus.wb_sel_i = 4'hF;
        a_bus.wb_dat_i = 32'h1234_5678;
        @(posedge clk);
        @(negedge clk);
        a_bus.wb_adr_i = 32'h0000_0304;
        a_bus.wb_dat_i = 32'h9ABC_DEF0;
        @(posedge clk);
        @(negedge clk);
        a_idle();
        #1;
        n_ack = 0;
        n_err = 0;
        for (int j = 0; j < 6; j++) begin
            if (a_bus.wb_ack_o) n_ack++;
            if (a_bus.wb_err_o) n_err++;
            @(negedge clk);
        end
        check("t5_ack_seen", 32'(n_ack), 32'd0);
        check("t5_err_seen", 32'(n_err), 32'd0);
        check("t5_stall",    32'(a_bus.wb_stall_o), 32'd0);
        xfer(1'b0, 32'h0000_0404, 4'hF, 32'h0, n_ack, n_err, lat, rdat);
        check("t5_wcnt", rdat, 32'd3);
        xfer(1'b0, 32'h0000_0300, 4'hF, 32'h0, n_ack, n_err, lat, rdat);
        check("t5_ram0", rdat, 32'h1234_5678);
        xfer(1'b0, 32'h0000_0304, 4'hF, 32'h0, n_ack, n_err, lat, rdat);
        check("t5_ram1", rdat, 32'h9ABC_DEF0);
        xfer(1'b0, 32'h0000_0408, 4'hF, 32'h0, n_ack, n_err, lat, rdat);
        check("t5_rcnt", rdat, 32'd3);

        // T3: instance B, latency 4, depth 2
        b_burst(6, 1'b1, 32'hB000_0000, 1'b0);
        repeat (30) @(negedge clk);
        b_idle();
        check("t3_wr_drain", 32'(exp_q.size()), 32'd0);
        b_acks = 0;
        b_burst(6, 1'b0, 32'hB000_0000, 1'b1);
        repeat (30) @(negedge clk);
        b_idle();
        check("t3_acks",  32'(b_acks), 32'd6);
        check("t3_drain", 32'(exp_q.size()), 32'd0);

        // T6: reset with requests in flight on A
        @(negedge clk);
        a_bus.wb_cyc_i = 1'b1;
        a_bus.wb_stb_i = 1'b1;
        a_bus.wb_we_i  = 1'b0;
        a_bus.wb_adr_i = 32'h0000_021C;
        a_bus.wb_sel_i = 4'hF;
        @(posedge clk);
        @(negedge clk);
        a_bus.wb_adr_i = 32'h0000_0100;
        @(posedge clk);
        @(negedge clk);
        a_bus.wb_adr_i = 32'h0000_0104;
        @(posedge clk);
        #2;
        check("t6_ack_before", 32'(a_bus.wb_ack_o), 32'd1);
        a_bus.wb_stb_i = 1'b0;
        rst_n = 1'b0;
        #1;
        check("t6_ack",   32'(a_bus.wb_ack_o),   32'd0);
        check("t6_err",   32'(a_bus.wb_err_o),   32'd0);
        check("t6_stall", 32'(a_bus.wb_stall_o), 32'd0);
        check("t6_dat",   a_bus.wb_dat_o,        32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        a_idle();
        xfer(1'b0, 32'h0000_0408, 4'hF, 32'h0, n_ack, n_err, lat, rdat);
        check("t6_first_lat", 32'(lat), 32'd2);
        check("t6_first_ack", 32'(n_ack), 32'd1);
        check("t6_rcnt", rdat, 32'd0);
        xfer(1'b0, 32'h0000_0404, 4'hF, 32'h0, n_ack, n_err, lat, rdat);
        check("t6_wcnt", rdat, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
